// File: rtl/mux_nto1_scan.sv
// Registered N-to-1 channel sequencer with direct select, round-robin scan and freeze.
// y, y_valid, ch_idx and scan_wrap all update together, one cycle after the inputs.
module mux_nto1_scan #(
    parameter int N       = 8,
    parameter int W       = 4,
    parameter int DWELL_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N*W-1:0]           d,
    input  logic [$clog2(N)-1:0]     sel,
    input  logic [1:0]               mode,
    input  logic [N-1:0]             en_mask,
    input  logic [DWELL_W-1:0]       dwell,
    output logic [W-1:0]             y,
    output logic                     y_valid,
    output logic [$clog2(N)-1:0]     ch_idx,
    output logic                     scan_wrap
);

    localparam int SEL_W = $clog2(N);

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_FREEZE = 2'b10;

    logic [W-1:0]       y_q, y_d;
    logic               y_valid_q, y_valid_d;
    logic [SEL_W-1:0]   ch_idx_q, ch_idx_d;
    logic               scan_wrap_q, scan_wrap_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [1:0]         prev_mode_q, prev_mode_d;

    logic [W-1:0]       ch_data [N];
    logic [SEL_W-1:0]   s;
    logic               sel_ok;

    // Circular search for an enabled channel; the exclusive form visits start last,
    // so a single enabled channel finds itself.
    function automatic logic [SEL_W-1:0] find_enabled(
        input logic [SEL_W-1:0] start,
        input logic [N-1:0]     mask,
        input logic             inclusive
    );
        logic [SEL_W-1:0] r;
        logic [SEL_W-1:0] idx_s;
        logic             found;
        int               idx;
        r     = start;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = int'(start) + i + (inclusive ? 0 : 1);
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_s = SEL_W'(idx);
            if (!found && mask[idx_s]) begin
                r     = idx_s;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int k = 0; k < N; k++) begin
            ch_data[k] = d[k*W +: W];
        end
    end

    assign sel_ok = (int'(sel) < N);

    always_comb begin
        y_d         = y_q;
        y_valid_d   = y_valid_q;
        ch_idx_d    = ch_idx_q;
        cnt_d       = cnt_q;
        scan_wrap_d = 1'b0;
        prev_mode_d = mode;
        s           = ch_idx_q;

        case (mode)
            MODE_DIRECT: begin
                cnt_d = '0;
                if (sel_ok) begin
                    s         = sel;
                    ch_idx_d  = s;
                    y_d       = ch_data[s];
                    y_valid_d = 1'b1;
                end else begin
                    y_d       = '0;
                    y_valid_d = 1'b0;
                end
            end
            MODE_SCAN: begin
                if (en_mask == '0) begin
                    // Recording freeze forces the entry search once the mask returns.
                    y_d         = '0;
                    y_valid_d   = 1'b0;
                    prev_mode_d = MODE_FREEZE;
                end else begin
                    if (prev_mode_q != MODE_SCAN) begin
                        cnt_d = '0;
                        s     = find_enabled(ch_idx_q, en_mask, 1'b1);
                    end else if (cnt_q < dwell) begin
                        cnt_d = cnt_q + 1'b1;
                        s     = ch_idx_q;
                    end else begin
                        cnt_d       = '0;
                        s           = find_enabled(ch_idx_q, en_mask, 1'b0);
                        scan_wrap_d = (s <= ch_idx_q);
                    end
                    ch_idx_d  = s;
                    y_d       = ch_data[s];
                    y_valid_d = 1'b1;
                end
            end
            default: begin
                if (prev_mode_q == MODE_SCAN) begin
                    cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            ch_idx_q    <= '0;
            scan_wrap_q <= 1'b0;
            cnt_q       <= '0;
            prev_mode_q <= MODE_FREEZE;
        end else begin
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            ch_idx_q    <= ch_idx_d;
            scan_wrap_q <= scan_wrap_d;
            cnt_q       <= cnt_d;
            prev_mode_q <= prev_mode_d;
        end
    end

    assign y         = y_q;
    assign y_valid   = y_valid_q;
    assign ch_idx    = ch_idx_q;
    assign scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Directed bench for mux_nto1_scan: reset, direct latency, scan dwell/wrap, masks,
// freeze/resume and mid-scan reset, all against hand-computed expectations.
module tb_mux_nto1_scan;

    localparam int N       = 8;
    localparam int W       = 4;
    localparam int DWELL_W = 8;
    localparam int SEL_W   = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N*W-1:0]       d;
    logic [SEL_W-1:0]     sel;
    logic [1:0]           mode;
    logic [N-1:0]         en_mask;
    logic [DWELL_W-1:0]   dwell;
    logic [W-1:0]         y;
    logic                 y_valid;
    logic [SEL_W-1:0]     ch_idx;
    logic                 scan_wrap;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_nto1_scan #(.N(N), .W(W), .DWELL_W(DWELL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d),
        .sel       (sel),
        .mode      (mode),
        .en_mask   (en_mask),
        .dwell     (dwell),
        .y         (y),
        .y_valid   (y_valid),
        .ch_idx    (ch_idx),
        .scan_wrap (scan_wrap)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic checkState(input string tag, input logic [3:0] ey, input logic ev,
                              input logic [2:0] ech, input logic ew);
        checkOutput({tag, ".y"},         32'(y),         32'(ey));
        checkOutput({tag, ".y_valid"},   32'(y_valid),   32'(ev));
        checkOutput({tag, ".ch_idx"},    32'(ch_idx),    32'(ech));
        checkOutput({tag, ".scan_wrap"}, 32'(scan_wrap), 32'(ew));
    endtask

    // Advance one edge and settle just after it, so outputs are sampled away from the edge.
    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [2:0] s,
                                 input logic [7:0] mask, input logic [7:0] dw);
        mode    = m;
        sel     = s;
        en_mask = mask;
        dwell   = dw;
        stepClk();
    endtask

    task automatic setChan(input int k, input logic [3:0] v);
        d[k*W +: W] = v;
    endtask

    initial begin
        int exp_ch3 [10] = '{0, 0, 0, 2, 2, 2, 7, 7, 7, 0};
        int exp_ch5 [5]  = '{0, 0, 0, 2, 2};

        for (int k = 0; k < N; k++) begin
            setChan(k, 4'(k + 3));
        end
        rst_n   = 1'b0;
        mode    = 2'b01;
        sel     = '0;
        en_mask = 8'hFF;
        dwell   = 8'd2;

        $display("[TB] reset");
        stepClk();
        stepClk();
        checkState("reset", 4'h0, 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(2'b01, 3'd0, 8'hFF, 8'd2);
        checkState("reset_release", 4'h3, 1'b1, 3'd0, 1'b0);

        $display("[TB] direct latency");
        applyStimulus(2'b00, 3'd2, 8'hFF, 8'd2);
        checkState("direct_sel2", 4'h5, 1'b1, 3'd2, 1'b0);
        applyStimulus(2'b00, 3'd5, 8'hFF, 8'd2);
        checkState("direct_sel5", 4'h8, 1'b1, 3'd5, 1'b0);
        applyStimulus(2'b00, 3'd7, 8'hFF, 8'd2);
        checkState("direct_sel7", 4'hA, 1'b1, 3'd7, 1'b0);
        setChan(7, 4'h0);
        applyStimulus(2'b00, 3'd7, 8'hFF, 8'd2);
        checkState("direct_live_d", 4'h0, 1'b1, 3'd7, 1'b0);
        setChan(7, 4'hA);
        applyStimulus(2'b00, 3'd0, 8'hFF, 8'd2);
        checkState("direct_sel0", 4'h3, 1'b1, 3'd0, 1'b0);

        $display("[TB] scan dwell=2 mask=85");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(2'b01, 3'd0, 8'h85, 8'd2);
            checkState($sformatf("scan3_%0d", i), 4'(exp_ch3[i] + 3), 1'b1,
                       3'(exp_ch3[i]), (i == 9));
        end

        $display("[TB] single and empty mask");
        applyStimulus(2'b01, 3'd0, 8'h10, 8'd0);
        checkState("single_first", 4'h7, 1'b1, 3'd4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b01, 3'd0, 8'h10, 8'd0);
            checkState($sformatf("single_%0d", i), 4'h7, 1'b1, 3'd4, 1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(2'b01, 3'd0, 8'h00, 8'd0);
            checkState($sformatf("empty_%0d", i), 4'h0, 1'b0, 3'd4, 1'b0);
        end
        applyStimulus(2'b01, 3'd0, 8'h01, 8'd0);
        checkState("mask_restore", 4'h3, 1'b1, 3'd0, 1'b0);

        $display("[TB] freeze and resume");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b01, 3'd0, 8'h85, 8'd3);
            checkState($sformatf("pre_freeze_%0d", i), 4'(exp_ch5[i] + 3), 1'b1,
                       3'(exp_ch5[i]), 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            setChan(2, 4'(4'hD ^ 4'(i)));
            applyStimulus((i < 3) ? 2'b10 : 2'b11, 3'd6, 8'h85, 8'd3);
            checkState($sformatf("freeze_%0d", i), 4'h5, 1'b1, 3'd2, 1'b0);
        end
        setChan(2, 4'hC);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b01, 3'd0, 8'h85, 8'd3);
            checkState($sformatf("resume_%0d", i), 4'hC, 1'b1, 3'd2, 1'b0);
        end
        applyStimulus(2'b01, 3'd0, 8'h85, 8'd3);
        checkState("resume_advance", 4'hA, 1'b1, 3'd7, 1'b0);

        $display("[TB] mid-scan reset");
        applyStimulus(2'b01, 3'd0, 8'h20, 8'd0);
        checkState("to_ch5", 4'h8, 1'b1, 3'd5, 1'b1);
        rst_n = 1'b0;
        stepClk();
        checkState("mid_reset", 4'h0, 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(2'b01, 3'd0, 8'hFF, 8'd1);
        checkState("restart_0", 4'h3, 1'b1, 3'd0, 1'b0);
        applyStimulus(2'b01, 3'd0, 8'hFF, 8'd1);
        checkState("restart_1", 4'h3, 1'b1, 3'd0, 1'b0);
        applyStimulus(2'b01, 3'd0, 8'hFF, 8'd1);
        checkState("restart_2", 4'h4, 1'b1, 3'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_nto1_scan.md
Name: mux_nto1_scan

Overview:
- Parametrised, registered N-to-1 multiplexer of W-bit channels. It generalises the team's fixed 4-to-1, 1-bit mux.
- Adds three modes: direct select, automatic round-robin scan with programmable dwell and a channel-enable mask, and freeze.
- Used as the channel sequencer feeding the display/measurement datapath.
- Output is registered with a fixed 1-cycle latency. A valid flag and the active channel index are reported alongside the data.

Parameters:
N, 8, number of input channels (N >= 2)
W, 4, width of each channel in bits
DWELL_W, 8, width of the dwell counter/config
SEL_W, $clog2(N), width of channel index (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
d  input  N*W  packed channel data, channel k at d[k*W +: W]
sel  input  SEL_W  channel select used in direct mode
mode  input  2  00 direct, 01 scan, 10 freeze, 11 treated as freeze
en_mask  input  N  bit k=1 enables channel k for scan
dwell  input  DWELL_W  scan holds each channel dwell+1 cycles
y  output  W  registered selected data
y_valid  output  1  y holds valid channel data
ch_idx  output  SEL_W  index of channel currently driving y
scan_wrap  output  1  one-cycle pulse when scan wraps to a lower-or-equal index

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - y=0, y_valid=0, ch_idx=0, scan_wrap=0.
  - Dwell counter=0, previous-mode register=freeze.
  - Reset wins over all other inputs.
- Structure:
  - Each cycle, combinational next-index s and next-valid v are computed.
  - At the edge, ch_idx<=s, y<=d[s], y_valid<=v. This keeps y and ch_idx always consistent.
  - Latency is 1 cycle: y at edge t+1 reflects d sampled at edge t.
- Direct (00):
  - sel<N: s=sel, v=1.
  - sel>=N (non-power-of-2 N): y<=0, y_valid<=0, ch_idx holds.
  - en_mask is ignored. Dwell counter is held at 0. scan_wrap=0.
- Scan (01):
  - Entry cycle (previous mode != scan):
    - Dwell counter<=0.
    - s = first enabled index at or after current ch_idx, searching ascending circularly.
  - Steady state:
    - If counter < dwell: counter++, s=ch_idx.
    - If counter >= dwell (expiry): counter<=0, s = next enabled index strictly after ch_idx, searching circularly.
  - dwell=0 advances every cycle.
  - dwell lowered mid-count below the counter: expiry fires on the next cycle.
  - Only one channel enabled: s equals ch_idx on expiry, and scan_wrap pulses.
  - scan_wrap=1 for exactly the cycle in which the expiry advance gives s <= ch_idx. Otherwise 0.
  - en_mask=0: y<=0, y_valid<=0, ch_idx and counter hold. On the first cycle the mask is nonzero again, the entry search applies.
  - Current channel disabled mid-dwell: it keeps output until expiry, then the search skips it.
- Freeze (10/11):
  - y, y_valid and ch_idx hold. Counter holds. scan_wrap=0.
  - d changes are not reflected on y.
- Mode switch:
  - Takes effect on the first edge after mode changes.
  - Any exit from scan clears the counter.
  - Freeze->scan re-runs the entry search from the frozen ch_idx.
- Data tracking: in direct and scan, y follows live d of the selected channel every cycle, not only at channel changes.

Test Plan:
1. Reset: assert rst_n=0 for 2 cycles with mode=01, en_mask=FF -> y=0, y_valid=0, ch_idx=0, scan_wrap=0; after release, the first edge gives ch_idx=0, y=d[0], y_valid=1.
2. Direct latency: N=8,W=4, d channel k = k+3, mode=00, sel steps 2,5,7 on consecutive edges -> y=5,8,A and ch_idx=2,5,7 one cycle behind each sel. Then sel=7 with a d[7] change to 0 -> y=0 on the next edge.
3. Scan with dwell: mode=01, en_mask=8'b1000_0101, dwell=2, start at ch_idx=0 -> ch_idx sequence 0,0,0,2,2,2,7,7,7,0. scan_wrap=1 only on the edge where ch_idx goes 7->0.
4. Single/empty mask: en_mask=8'b0001_0000, dwell=0 -> ch_idx=4 every cycle with scan_wrap=1 every cycle. Set en_mask=0 -> y=0, y_valid=0, ch_idx stays 4. Restore 8'h01 -> ch_idx=0, y_valid=1 next edge.
5. Freeze and resume: scan with dwell=3, freeze at counter=1 on ch_idx=2 for 5 cycles while d[2] changes -> y and ch_idx are unchanged. Return to 01 -> counter restarts, ch_idx=2 for 4 cycles, then next enabled.
6. Mid-operation reset: during scan at ch_idx=5, pull rst_n=0 for one edge -> all outputs 0. On release (mode=01), scan restarts from channel 0 with the counter cleared.
